// File: rtl/mem_interface.sv
// Memory interface stage: MAR/MDR, word-addressed RAM and wait-stated
// read/write accesses with a one-cycle completion strobe.
module mem_interface #(
    parameter int DATA_W      = 16,
    parameter int MEM_AW      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic              ena_mdr,
    output logic [DATA_W-1:0] mdr_out,
    output logic              mdr_drive,
    output logic [DATA_W-1:0] mar_out,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam bit ZERO_WS = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [DATA_W-1:0]   acc_data_q, acc_data_d;
    logic [MEM_AW-1:0]   acc_addr_q, acc_addr_d;
    logic                acc_we_q, acc_we_d;
    logic                err_q, err_d;

    logic                commit;
    logic                cm_we;
    logic [MEM_AW-1:0]   cm_addr;
    logic [DATA_W-1:0]   cm_data;

    logic [DATA_W-1:0]   mem_q [2**MEM_AW];

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        acc_addr_d = acc_addr_q;
        acc_data_d = acc_data_q;
        acc_we_d   = acc_we_q;
        err_d      = err_q;
        commit     = 1'b0;
        cm_addr    = acc_addr_q;
        cm_data    = acc_data_q;
        cm_we      = acc_we_q;

        unique case (state_q)
            IDLE: begin
                if (mem_en) begin
                    acc_addr_d = mar_q[MEM_AW-1:0];
                    acc_data_d = mdr_q;
                    acc_we_d   = mem_we;
                    wcnt_d     = WS_LOAD;
                    if (ZERO_WS) begin
                        // No wait states: commit straight from the live MAR/MDR
                        commit  = 1'b1;
                        cm_addr = mar_q[MEM_AW-1:0];
                        cm_data = mdr_q;
                        cm_we   = mem_we;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (wcnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != BUSY) begin
            if (ld_mar) mar_d = bus_in;
            if (ld_mdr) mdr_d = bus_in;
        end else if (ld_mar || ld_mdr) begin
            err_d = 1'b1;
        end

        // Read data takes priority over a same-edge ld_mdr
        if (commit && !cm_we) mdr_d = mem_q[cm_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wcnt_q     <= 4'd0;
            mar_q      <= '0;
            mdr_q      <= '0;
            acc_addr_q <= '0;
            acc_data_q <= '0;
            acc_we_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            acc_addr_q <= acc_addr_d;
            acc_data_q <= acc_data_d;
            acc_we_q   <= acc_we_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && cm_we) mem_q[cm_addr] <= cm_data;
    end

    assign mdr_out   = mdr_q;
    assign mar_out   = mar_q;
    assign mdr_drive = ena_mdr;
    assign mem_ready = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface with one and zero wait states,
// read results checked through an expected-data queue.
module tb_mem_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mem_en, mem_we, ena_mdr;

    logic [15:0] mdr1, mar1, mdr0, mar0;
    logic        drv1, rdy1, busy1, err1;
    logic        drv0, rdy0, busy0, err0;

    int          n_chk = 0;
    int          n_fail = 0;
    int          lat;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    always #5 clk = ~clk;

    mem_interface #(.DATA_W(16), .MEM_AW(8), .WAIT_STATES(1)) u1 (
        .clk(clk), .reset(reset), .bus_in(bus_in),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mem_en(mem_en),
        .mem_we(mem_we), .ena_mdr(ena_mdr), .mdr_out(mdr1),
        .mdr_drive(drv1), .mar_out(mar1), .mem_ready(rdy1),
        .busy(busy1), .err(err1)
    );

    mem_interface #(.DATA_W(16), .MEM_AW(8), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .bus_in(bus_in),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mem_en(mem_en),
        .mem_we(mem_we), .ena_mdr(ena_mdr), .mdr_out(mdr0),
        .mdr_drive(drv0), .mar_out(mar0), .mem_ready(rdy0),
        .busy(busy0), .err(err0)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ld_reg(input bit to_mdr, input logic [15:0] v);
        @(negedge clk);
        bus_in = v;
        ld_mar = !to_mdr;
        ld_mdr = to_mdr;
        @(negedge clk);
        ld_mar = 1'b0;
        ld_mdr = 1'b0;
    endtask

    task automatic access1(input logic we, input logic [15:0] rd,
                           input string tag);
        mem_en = 1'b1;
        mem_we = we;
        if (!we) exp_q.push_back(rd);
        @(negedge clk);
        mem_en = 1'b0;
        lat = 1;
        while (!rdy1 && lat < 20) begin
            chk({tag, "_busy"}, 16'(busy1), 16'h1);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 16'(lat), 16'd2);
        chk({tag, "_rdy_busy"}, 16'(busy1), 16'h0);
        if (!we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, mdr1, e);
        end
        @(negedge clk);
        chk({tag, "_rdy_pulse"}, 16'(rdy1), 16'h0);
    endtask

    initial begin
        reset = 1'b1; bus_in = '0; ld_mar = 0; ld_mdr = 0;
        mem_en = 0; mem_we = 0; ena_mdr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_mar", mar1, 16'h0);
        chk("rst_mdr", mdr1, 16'h0);
        chk("rst_rdy", 16'(rdy1), 16'h0);
        chk("rst_busy", 16'(busy1), 16'h0);
        chk("rst_err", 16'(err1), 16'h0);
        ena_mdr = 1'b1;
        #1 chk("drive_on", 16'(drv1), 16'h1);
        ena_mdr = 1'b0;
        #1 chk("drive_off", 16'(drv1), 16'h0);

        // Write then read back
        ld_reg(0, 16'h0012);
        ld_reg(1, 16'hBEEF);
        access1(1, 16'h0, "wr12");
        ld_reg(1, 16'h0000);
        chk("mdr_clr", mdr1, 16'h0);
        access1(0, 16'hBEEF, "rd12");

        // Address aliasing on MAR upper bits
        ld_reg(0, 16'h0105);
        ld_reg(1, 16'h1234);
        access1(1, 16'h0, "wr105");
        ld_reg(0, 16'h0005);
        chk("mar_alias", mar1, 16'h0005);
        access1(0, 16'h1234, "rd005");

        // Load during BUSY
        ld_reg(0, 16'h0040);
        ld_reg(1, 16'h7777);
        mem_en = 1'b1; mem_we = 1'b1;
        @(negedge clk);
        mem_en = 1'b0;
        chk("perr_busy", 16'(busy1), 16'h1);
        ld_mar = 1'b1; bus_in = 16'h00FF;
        @(negedge clk);
        ld_mar = 1'b0;
        chk("perr_mar", mar1, 16'h0040);
        chk("perr_err", 16'(err1), 16'h1);
        chk("perr_rdy", 16'(rdy1), 16'h1);
        @(negedge clk);
        access1(0, 16'h7777, "perr_rd");
        chk("perr_sticky", 16'(err1), 16'h1);

        // Reset in the middle of a write
        ld_reg(0, 16'h0030);
        ld_reg(1, 16'h5555);
        access1(1, 16'h0, "pre30");
        ld_reg(1, 16'hAAAA);
        mem_en = 1'b1; mem_we = 1'b1;
        @(negedge clk);
        mem_en = 1'b0;
        chk("abort_busy", 16'(busy1), 16'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_idle", 16'(busy1), 16'h0);
        chk("abort_err", 16'(err1), 16'h0);
        chk("abort_mdr", mdr1, 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_nordy", 16'(rdy1), 16'h0);
            @(negedge clk);
        end
        ld_reg(0, 16'h0030);
        access1(0, 16'h5555, "abort_rd");

        // Zero wait states: back-to-back reads with mem_en held
        ld_reg(0, 16'h0001);
        ld_reg(1, 16'h1111);
        access1(1, 16'h0, "wr1");
        ld_reg(0, 16'h0002);
        ld_reg(1, 16'h2222);
        access1(1, 16'h0, "wr2");
        ld_reg(0, 16'h0001);
        chk("z_mar", mar0, 16'h0001);
        mem_en = 1'b1; mem_we = 1'b0;
        ld_mdr = 1'b1; bus_in = 16'hDEAD;
        exp_q.push_back(16'h1111);
        @(negedge clk);
        chk("z_rdy_a", 16'(rdy0), 16'h1);
        chk("z_busy_a", 16'(busy0), 16'h0);
        e = exp_q.pop_front();
        chk("z_data_a", mdr0, e);
        ld_mdr = 1'b0; ld_mar = 1'b1; bus_in = 16'h0002;
        exp_q.push_back(16'h2222);
        @(negedge clk);
        chk("z_rdy_gap", 16'(rdy0), 16'h0);
        chk("z_busy_gap", 16'(busy0), 16'h0);
        ld_mar = 1'b0; ld_mdr = 1'b1; bus_in = 16'hDEAD;
        @(negedge clk);
        chk("z_rdy_b", 16'(rdy0), 16'h1);
        chk("z_busy_b", 16'(busy0), 16'h0);
        e = exp_q.pop_front();
        chk("z_data_b", mdr0, e);
        mem_en = 1'b0; ld_mdr = 1'b0;
        @(negedge clk);
        chk("z_idle", 16'(rdy0), 16'h0);
        chk("z_err", 16'(err0), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
